// File: rtl/io_capture_pkg.sv
// Shared constants for the I/O capture register.
// Status bit positions, event counter geometry and status word packing.
package io_capture_pkg;

    localparam int unsigned STAT_VALID      = 0;
    localparam int unsigned STAT_OVERRUN    = 1;
    localparam int unsigned STAT_INTEN      = 2;
    localparam int unsigned STAT_CNTCLR     = 3;

    localparam int unsigned EVENT_CNT_LSB   = 16;
    localparam int unsigned EVENT_CNT_WIDTH = 16;

    typedef logic [EVENT_CNT_WIDTH-1:0] event_cnt_t;

    localparam event_cnt_t EVENT_CNT_MAX = '1;

    // Layout: {EventCount, 12'b0, 1'b0, IntEn, Overrun, Valid}
    function automatic logic [31:0] pack_status(
        input event_cnt_t cnt,
        input logic       inten,
        input logic       overrun,
        input logic       valid
    );
        logic [31:0] w;
        w = '0;
        w[EVENT_CNT_LSB +: EVENT_CNT_WIDTH] = cnt;
        w[STAT_INTEN]   = inten;
        w[STAT_OVERRUN] = overrun;
        w[STAT_VALID]   = valid;
        return w;
    endfunction

endpackage

// File: rtl/IO_AccessItf.sv
// Processor-side register access bundle shared by the peripheral registers.
// SlavePort: Clock, Reset (sync, active-high), WrEn, WrData[31:0] as inputs.
interface IO_AccessItf;

    logic        Clock;
    logic        Reset;
    logic        WrEn;
    logic [31:0] WrData;

    modport SlavePort (
        input Clock,
        input Reset,
        input WrEn,
        input WrData
    );

endinterface

// File: rtl/RegisterRstEn.sv
// Generic register with synchronous active-high reset and load enable.
// Ports: clk_i, rst_i, en_i, d_i[WIDTH] in; q_o[WIDTH] out.
module RegisterRstEn #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= RST_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/io_capture_register.sv
// I/O-written, processor-read capture register with sticky status and IRQ.
// Ports: Sys_Interface (Clock/Reset/WrEn/WrData), Sys_DataSelect,
//   Sys_StatusSelect, Io_Data, Io_Strobe in; Sys_RdData, Sys_RdStatus,
//   Sys_Irq out.
module io_capture_register
    import io_capture_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    IO_AccessItf.SlavePort         Sys_Interface,
    input  logic                   Sys_DataSelect,
    input  logic                   Sys_StatusSelect,
    output logic [DATA_WIDTH-1:0]  Sys_RdData,
    output logic [31:0]            Sys_RdStatus,
    output logic                   Sys_Irq,
    input  logic [DATA_WIDTH-1:0]  Io_Data,
    input  logic                   Io_Strobe
);

    logic       clk;
    logic       rst;

    logic       strobe_q;
    logic       valid_q;
    logic       valid_d;
    logic       overrun_q;
    logic       overrun_d;
    logic       inten_q;
    logic       inten_d;
    event_cnt_t cnt_q;
    event_cnt_t cnt_d;
    logic       irq_q;

    logic       capture;
    logic       stat_wr;
    logic       clr_valid;
    logic       clr_overrun;
    logic       clr_cnt;

    assign clk = Sys_Interface.Clock;
    assign rst = Sys_Interface.Reset;

    // The data register is read-only from the processor side, so a write
    // through the data select and the reserved write bits do nothing.
    logic unused_ok;
    assign unused_ok = ^{Sys_DataSelect,
                         Sys_Interface.WrData[31:STAT_CNTCLR+1]};

    assign capture     = Io_Strobe & ~strobe_q;
    assign stat_wr     = Sys_Interface.WrEn & Sys_StatusSelect;
    assign clr_valid   = stat_wr & Sys_Interface.WrData[STAT_VALID];
    assign clr_overrun = stat_wr & Sys_Interface.WrData[STAT_OVERRUN];
    assign clr_cnt     = stat_wr & Sys_Interface.WrData[STAT_CNTCLR];

    RegisterRstEn #(
        .WIDTH     (DATA_WIDTH),
        .RST_VALUE (RESET_VALUE)
    ) u_data_reg (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (capture),
        .d_i   (Io_Data),
        .q_o   (Sys_RdData)
    );

    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        inten_d   = inten_q;
        cnt_d     = cnt_q;

        if (stat_wr) begin
            inten_d = Sys_Interface.WrData[STAT_INTEN];
        end

        if (clr_valid) begin
            valid_d = 1'b0;
        end
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end

        if (capture) begin
            valid_d = 1'b1;
            // A same-cycle acknowledge consumed the old data: no overrun.
            // Setting takes priority over a same-cycle clear.
            if (valid_q && !clr_valid) begin
                overrun_d = 1'b1;
            end
            if (clr_cnt) begin
                cnt_d = event_cnt_t'(1);
            end else if (cnt_q != EVENT_CNT_MAX) begin
                cnt_d = cnt_q + event_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // High so a strobe held through reset release is not an edge.
            strobe_q  <= 1'b1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            inten_q   <= 1'b0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            strobe_q  <= Io_Strobe;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            inten_q   <= inten_d;
            cnt_q     <= cnt_d;
            irq_q     <= valid_q & inten_q;
        end
    end

    assign Sys_RdStatus = pack_status(cnt_q, inten_q, overrun_q, valid_q);
    assign Sys_Irq      = irq_q;

endmodule

// File: tb/tb_io_capture_register.sv
// Randomized and directed bench for io_capture_register.
// Compares against a cycle-level event model of the register rules.
module tb_io_capture_register;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] RV = 32'hDEAD_BEEF;

    IO_AccessItf sys_if();

    logic          data_sel;
    logic          stat_sel;
    logic [DW-1:0] rd_data;
    logic [31:0]   rd_status;
    logic          irq;
    logic [DW-1:0] io_data;
    logic          io_strobe;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_data;
    bit            m_valid;
    bit            m_ovr;
    bit            m_inten;
    int            m_count;
    bit            m_irq;
    bit            m_prev;

    io_capture_register #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (RV)
    ) dut (
        .Sys_Interface    (sys_if),
        .Sys_DataSelect   (data_sel),
        .Sys_StatusSelect (stat_sel),
        .Sys_RdData       (rd_data),
        .Sys_RdStatus     (rd_status),
        .Sys_Irq          (irq),
        .Io_Data          (io_data),
        .Io_Strobe        (io_strobe)
    );

    initial sys_if.Clock = 1'b0;
    always #5 sys_if.Clock = ~sys_if.Clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w = '0;
        w[31:16] = m_count[15:0];
        w[2] = m_inten;
        w[1] = m_ovr;
        w[0] = m_valid;
        return w;
    endfunction

    // Apply one cycle of inputs, advance the model, optionally compare.
    task automatic cyc(input bit rst, input bit stb,
                       input bit wr, input bit dsel, input bit ssel,
                       input logic [31:0] wd, input logic [DW-1:0] d,
                       input bit chk);
        bit cap;
        bit swr;
        bit was_valid;
        sys_if.Reset  = rst;
        sys_if.WrEn   = wr;
        sys_if.WrData = wd;
        data_sel      = dsel;
        stat_sel      = ssel;
        io_strobe     = stb;
        io_data       = d;
        @(posedge sys_if.Clock);
        #1;
        if (rst) begin
            m_data  = RV;
            m_valid = 0;
            m_ovr   = 0;
            m_inten = 0;
            m_count = 0;
            m_irq   = 0;
            m_prev  = 1;
        end else begin
            cap       = stb && !m_prev;
            m_prev    = stb;
            swr       = wr && ssel;
            m_irq     = m_valid && m_inten;
            was_valid = m_valid;
            if (swr && wd[1]) m_ovr = 0;
            if (swr && wd[0]) m_valid = 0;
            if (swr && wd[3]) m_count = 0;
            if (swr) m_inten = wd[2];
            if (cap) begin
                m_data = d;
                if (was_valid && !(swr && wd[0])) m_ovr = 1;
                m_valid = 1;
                m_count = (m_count + 1 > 65535) ? 65535 : m_count + 1;
            end
        end
        if (chk) begin
            check("rd_data", rd_data, m_data);
            check("rd_status", rd_status, exp_status());
            check("irq", {31'b0, irq}, {31'b0, m_irq});
        end
    endtask

    task automatic idle(input bit stb);
        cyc(0, stb, 0, 0, 0, '0, '0, 1);
    endtask

    task automatic swrite(input logic [31:0] wd, input bit stb,
                          input logic [DW-1:0] d);
        cyc(0, stb, 1, 0, 1, wd, d, 1);
    endtask

    initial begin
        // Reset with strobe held high across release
        cyc(1, 1, 0, 0, 0, '0, 32'h1234_5678, 1);
        cyc(1, 1, 0, 0, 0, '0, 32'h1234_5678, 1);
        cyc(0, 1, 0, 0, 0, '0, 32'h1234_5678, 1);
        check("rst_status", rd_status, 32'h0);
        check("rst_data", rd_data, RV);
        idle(0);

        // Single pulse, IntEn off
        cyc(0, 1, 0, 0, 0, '0, 32'hA5A5_0001, 1);
        idle(0);
        check("cap_data", rd_data, 32'hA5A5_0001);
        check("cap_status", rd_status, 32'h0001_0001);
        check("cap_noirq", {31'b0, irq}, 32'h0);
        swrite(32'h1, 0, '0);

        // IntEn then capture: IRQ one cycle after Valid
        swrite(32'h4, 0, '0);
        cyc(0, 1, 0, 0, 0, '0, 32'h0BAD_F00D, 1);
        check("irq_lag", {31'b0, irq}, 32'h0);
        idle(0);
        check("irq_set", {31'b0, irq}, 32'h1);
        swrite(32'h5, 0, '0);
        check("irq_hold", {31'b0, irq}, 32'h1);
        idle(0);
        check("irq_clr", {31'b0, irq}, 32'h0);
        swrite(32'h8, 0, '0);

        // Overrun on back-to-back captures
        cyc(0, 1, 0, 0, 0, '0, 32'h11, 1);
        idle(0);
        cyc(0, 1, 0, 0, 0, '0, 32'h22, 1);
        idle(0);
        check("ovr_data", rd_data, 32'h22);
        check("ovr_status", rd_status, 32'h0002_0003);
        swrite(32'h2, 0, '0);
        check("ovr_clr", rd_status, 32'h0002_0001);

        // Capture with same-cycle Valid clear
        cyc(0, 1, 1, 0, 1, 32'h1, 32'h33, 1);
        check("ackcap", rd_status[1:0], 32'h1);

        // Data-select write is ignored
        cyc(0, 0, 1, 1, 0, 32'hFFFF_FFFF, '0, 1);

        // Capture with same-cycle count clear
        cyc(0, 1, 1, 0, 1, 32'h8, 32'h44, 1);
        check("cntclr_cap", rd_status[31:16], 32'h1);
        idle(0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r_rst;
            bit r_wr;
            bit r_ds;
            r_rst = ($urandom_range(0, 199) == 0);
            r_wr  = ($urandom_range(0, 3) == 0);
            r_ds  = ($urandom_range(0, 7) == 0);
            cyc(r_rst, 1'($urandom_range(0, 1)), r_wr | r_ds, r_ds,
                r_wr, $urandom, $urandom, 1);
        end

        // Saturation of the event counter
        swrite(32'h8, 0, '0);
        for (int i = 0; i < 65535; i++) begin
            cyc(0, 1, 0, 0, 0, '0, i, 0);
            cyc(0, 0, 0, 0, 0, '0, i, 0);
        end
        check("sat_cnt", rd_status[31:16], 32'hFFFF);
        check("sat_model", rd_status, exp_status());
        cyc(0, 1, 0, 0, 0, '0, 32'h5A5A_5A5A, 1);
        check("sat_hold", rd_status[31:16], 32'hFFFF);
        idle(0);
        cyc(0, 1, 0, 0, 0, '0, 32'h6B6B_6B6B, 1);
        check("sat_hold2", rd_status[31:16], 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_capture_register.md
# io_capture_register

Peripheral register written by I/O logic and read by the processor: the mirror of the processor-written, I/O-invisible read/write register. A rising edge on the I/O strobe latches the I/O data word into a capture register and records the event in sticky status flags. The processor reads the data and status, acknowledges events with write-1-to-clear bits, and optionally receives an interrupt request. Sits in the peripheral block beside the other I/O registers and is decoded by the same register-select logic.

## Interface
- DATA_WIDTH, 32: width of captured data; 1..32.
- RESET_VALUE, '0: capture register reset value, DATA_WIDTH bits.
- Sys_Interface.Clock  in  1  the single clock; all state on its rising edge.
- Sys_Interface.Reset  in  1  synchronous, active-high reset.
- Sys_Interface (IO_AccessItf.SlavePort)  —  —  also supplies WrEn (1) and WrData (32).
- Sys_DataSelect  in  1  selects the capture data register; writes to it are ignored.
- Sys_StatusSelect  in  1  selects the status/control register.
- Sys_RdData  out  DATA_WIDTH  capture register contents.
- Sys_RdStatus  out  32  {EventCount[15:0], 12'b0, 1'b0, IntEn, Overrun, Valid}.
- Sys_Irq  out  1  registered interrupt request, Valid & IntEn.
- Io_Data  in  DATA_WIDTH  data from I/O logic, Clock domain.
- Io_Strobe  in  1  capture request level from I/O logic, Clock domain.

## Operation
- StrobeQ registers Io_Strobe. Capture = Io_Strobe & ~StrobeQ.
- On Capture: the data register loads Io_Data. Valid is set. EventCount increments and saturates at 16'hFFFF.
- Overrun is set when Capture occurs while Valid=1 and the same cycle does not clear Valid. New data always overwrites old data.
- Status write (WrEn & Sys_StatusSelect):
  - WrData[0]=1 clears Valid.
  - WrData[1]=1 clears Overrun.
  - WrData[2] is loaded into IntEn.
  - WrData[3]=1 clears EventCount.
  - All other bits are ignored.
- Simultaneous Capture and clear of Valid: Valid stays 1 and Overrun is not set, because the processor acknowledged the old data.
- Simultaneous Capture and clear of EventCount: EventCount becomes 1.
- Simultaneous Overrun set and clear: set wins.
- Writes to the data select have no effect. Reads have no side effects.

## Timing
- Reset values:
  - Data register = RESET_VALUE.
  - Valid = Overrun = IntEn = 0.
  - EventCount = 0.
  - Sys_Irq = 0.
  - StrobeQ = 1, so a strobe held high through reset release does not capture.
- Capture latency: rising edge of Io_Strobe sampled at edge N. Sys_RdData, Valid and EventCount update after edge N. Sys_Irq updates after edge N+1.
- Minimum strobe period is 2 cycles (high 1, low 1). Strobe held high produces one capture.
- A status write at edge N is visible in Sys_RdStatus after edge N. Sys_Irq deasserts after edge N+1.
- Reset asserted mid-operation overrides all events in the same cycle.

## Structure
- Package io_capture_pkg holds:
  - Status bit positions: STAT_VALID=0, STAT_OVERRUN=1, STAT_INTEN=2, STAT_CNTCLR=3.
  - Event counter LSB: EVENT_CNT_LSB=16, with width 16.
- Reuse RegisterRstEn as the single sub-module for the data register:
  - Enable = Capture.
  - RST_VALUE = RESET_VALUE.
- Flags, counter, edge detector and Irq are written inline.

## Test plan
- Reset with Io_Strobe=1 held through release: no capture; Sys_RdStatus=0 and Sys_RdData=RESET_VALUE.
- Io_Data=32'hA5A5_0001 with a 1-cycle strobe pulse: Sys_RdData=32'hA5A5_0001, Valid=1, EventCount=1. IntEn=0 keeps Sys_Irq=0.
- Write status 32'h4 (IntEn), then capture: Sys_Irq=1 one cycle after Valid. Write 32'h1: Valid=0, and Sys_Irq=0 the cycle after.
- Two captures 32'h11 then 32'h22 without clear: Sys_RdData=32'h22, Overrun=1, EventCount=2. Write 32'h2: Overrun=0.
- Capture in the same cycle as a write of 32'h1 with Valid=1: Valid=1 and Overrun=0.
- Capture in the same cycle as a write of 32'h8: EventCount=1.
- 65536 captures: EventCount saturates at 16'hFFFF, and the next capture leaves it at 16'hFFFF.
